// File: rtl/hex_fmt_pkg.sv
// Shared constants and state encoding for the hex-to-ASCII UART formatter.
package hex_fmt_pkg;

  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_X    = 8'h78;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_A_UC = 8'h41;
  localparam logic [7:0] ASC_A_LC = 8'h61;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX0  = 3'd1,
    PFX1  = 3'd2,
    DIGIT = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } state_e;

endpackage

// File: rtl/nibble_to_ascii.sv
// Maps a 4-bit nibble to its ASCII hex digit; letter case chosen at elaboration.
module nibble_to_ascii
  import hex_fmt_pkg::*;
#(
  parameter int UPPERCASE = 1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  localparam logic [7:0] ASC_ALPHA = (UPPERCASE != 0) ? ASC_A_UC : ASC_A_LC;

  // Digits 0-9 offset from '0', digits 10-15 offset from 'A' or 'a'
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASC_0 + {4'd0, nibble};
    end else begin
      ascii = ASC_ALPHA + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_uart_formatter.sv
// Formats one binary word per handshake as ASCII hex text ("0x....\r\n")
// and streams it one character per accepted byte into the usb_uart input.
module hex_uart_formatter
  import hex_fmt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PREFIX_EN  = 1,
  parameter int NEWLINE_EN = 1,
  parameter int UPPERCASE  = 1
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [7:0]            uart_in_data,
  output logic                  uart_in_valid,
  input  logic                  uart_in_ready
);

  localparam int         NUM_DIGITS = DATA_WIDTH / 4;
  localparam logic [3:0] CNT_LAST   = 4'(NUM_DIGITS - 1);

  if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4 || DATA_WIDTH > 64) begin : g_bad_width
    $error("hex_uart_formatter: DATA_WIDTH must be a multiple of 4 in 4..64");
  end

  state_e                state_r;
  state_e                state_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] shift_s;
  logic [3:0]            cnt_r;
  logic [3:0]            cnt_s;
  logic                  word_ready_r;
  logic                  uart_in_valid_r;
  logic [7:0]            uart_in_data_r;
  logic                  ready_s;
  logic                  valid_s;
  logic [7:0]            data_s;
  logic [7:0]            digit_ascii_s;
  logic                  word_acc_s;
  logic                  byte_acc_s;

  assign word_acc_s = word_valid & word_ready_r;
  assign byte_acc_s = uart_in_valid_r & uart_in_ready;

  // Outputs are registered from the next state, so the digit shown is the top
  // nibble of the next shift value; a stalled byte therefore stays stable.
  nibble_to_ascii #(
    .UPPERCASE (UPPERCASE)
  ) u_nibble_to_ascii (
    .nibble (shift_s[DATA_WIDTH-1 -: 4]),
    .ascii  (digit_ascii_s)
  );

  // State, shift register and digit counter
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_r <= IDLE;
      shift_r <= '0;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: advance on every accepted byte, load on word accept
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (word_acc_s) begin
          shift_s = word_data;
          cnt_s   = CNT_LAST;
          if (PREFIX_EN != 0) begin
            state_s = PFX0;
          end else begin
            state_s = DIGIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      PFX0: begin
        if (byte_acc_s) begin
          state_s = PFX1;
        end else begin
          state_s = PFX0;
        end
      end
      PFX1: begin
        if (byte_acc_s) begin
          state_s = DIGIT;
        end else begin
          state_s = PFX1;
        end
      end
      DIGIT: begin
        if (byte_acc_s && cnt_r == 4'd0) begin
          if (NEWLINE_EN != 0) begin
            state_s = CR;
          end else begin
            state_s = IDLE;
          end
        end else if (byte_acc_s) begin
          shift_s = shift_r << 3'd4;
          cnt_s   = cnt_r - 4'd1;
          state_s = DIGIT;
        end else begin
          state_s = DIGIT;
        end
      end
      CR: begin
        if (byte_acc_s) begin
          state_s = LF;
        end else begin
          state_s = CR;
        end
      end
      LF: begin
        if (byte_acc_s) begin
          state_s = IDLE;
        end else begin
          state_s = LF;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode for the state about to be entered
  always_comb begin
    ready_s = 1'b0;
    valid_s = 1'b1;
    data_s  = 8'h00;
    case (state_s)
      IDLE: begin
        ready_s = 1'b1;
        valid_s = 1'b0;
        data_s  = 8'h00;
      end
      PFX0:    data_s = ASC_0;
      PFX1:    data_s = ASC_X;
      DIGIT:   data_s = digit_ascii_s;
      CR:      data_s = ASC_CR;
      LF:      data_s = ASC_LF;
      default: begin
        ready_s = 1'b0;
        valid_s = 1'b0;
        data_s  = 8'h00;
      end
    endcase
  end

  // Registered handshake outputs
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      word_ready_r    <= 1'b0;
      uart_in_valid_r <= 1'b0;
      uart_in_data_r  <= 8'h00;
    end else begin
      word_ready_r    <= ready_s;
      uart_in_valid_r <= valid_s;
      uart_in_data_r  <= data_s;
    end
  end

  assign word_ready    = word_ready_r;
  assign uart_in_valid = uart_in_valid_r;
  assign uart_in_data  = uart_in_data_r;

endmodule

// File: doc/hex_uart_formatter.md
Name: hex_uart_formatter

Overview:
Converts binary words into ASCII hexadecimal text, e.g. 0x1234ABCD becomes "0x1234ABCD\r\n". It drives the uart_in byte pipeline of usb_uart directly, so debug and status values can be printed on the USB serial port without host-side decoding. It takes one word per handshake and emits one character per accepted byte.

Parameters:
DATA_WIDTH, 32, input word width; multiple of 4, range 4..64
PREFIX_EN, 1, emit "0x" before the digits when 1
NEWLINE_EN, 1, emit "\r\n" after the digits when 1
UPPERCASE, 1, digits A-F are uppercase when 1, lowercase a-f when 0

Ports:
clk_48mhz  input  1  sole clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
word_data  input  DATA_WIDTH  word to format
word_valid  input  1  word_data is valid
word_ready  output  1  block can accept a word
uart_in_data  output  8  ASCII character to usb_uart
uart_in_valid  output  1  uart_in_data is valid
uart_in_ready  input  1  usb_uart accepts the byte

Behaviour:
- Transfer rule: a transfer occurs on any edge where valid && ready. This applies to both interfaces.
- Output registers: uart_in_data and uart_in_valid are registered outputs.
  - While uart_in_valid=1 and uart_in_ready=0, uart_in_data must stay stable and valid must stay high.
- Reset values: word_ready=0, uart_in_valid=0, uart_in_data=8'h00, state=IDLE, shift register cleared.
  - word_ready rises on the first edge after reset deasserts.
- States: IDLE, PFX0, PFX1, DIGIT, CR, LF.
- IDLE:
  - word_ready=1.
  - On word accept, load word_data into the shift register and set digit counter = DATA_WIDTH/4 - 1.
  - Next state is PFX0 if PREFIX_EN, else DIGIT.
  - uart_in_valid=1 on the next cycle with the first character. Latency is one cycle.
- word_ready=0 in every state except IDLE.
- PFX0 outputs '0' (8'h30). PFX1 outputs 'x' (8'h78). Each state advances on byte accept.
- DIGIT:
  - Outputs ASCII of the shift register's top nibble: 0-9 map to 8'h30-8'h39; 10-15 map to 8'h41-8'h46 (UPPERCASE=1) or 8'h61-8'h66 (UPPERCASE=0).
  - On accept, shift left by 4 and decrement the counter.
  - When the counter reaches 0 and that digit is accepted, go to CR if NEWLINE_EN, else IDLE.
- CR outputs 8'h0D and LF outputs 8'h0A. When LF is accepted, go to IDLE.
- Throughput: with uart_in_ready held high, one character per cycle with no bubbles inside a message.
  - Message length = 2*PREFIX_EN + DATA_WIDTH/4 + 2*NEWLINE_EN.
- Back-to-back words: uart_in_valid=0 for exactly one cycle (the IDLE cycle) between messages. word_ready=1 in that cycle.
- word_data is sampled only at accept. Later changes to word_data do not affect the message in flight.
- Leading zeros are always printed; no suppression.
- Reset mid-message:
  - The partial message is dropped: uart_in_valid=0 from the first edge with reset high.
  - The block never resumes the dropped message.
  - The next accepted word produces a complete message.
- word_valid while busy: ignored until IDLE. No word is ever lost or duplicated.
- Illegal DATA_WIDTH (not a multiple of 4, or outside 4..64) is a compile-time error via generate-time check.

Decomposition:
- Shared package hex_fmt_pkg:
  - ASCII constants ASC_0, ASC_X, ASC_CR, ASC_LF, ASC_A_UC, ASC_A_LC.
  - State enum/localparams for the six states.
- One combinational sub-module nibble_to_ascii: 4-bit nibble plus UPPERCASE parameter in, 8-bit ASCII out. Also reusable elsewhere.
- FSM, shift register and counter live in hex_uart_formatter. Expected size about 150 RTL lines.

Test Plan:
1. Default params, word 0x1234ABCD, uart_in_ready=1 -> bytes "0x1234ABCD\r\n" (30 78 31 32 33 34 41 42 43 44 0D 0A) on 12 consecutive cycles; first valid one cycle after accept.
2. Same word, uart_in_ready alternating 1/0 -> identical 12-byte sequence; data and valid held stable on every ready=0 cycle; no byte repeated.
3. UPPERCASE=0, word 0xDEADBEEF -> "0xdeadbeef\r\n"; word_ready=0 for all 12 bytes.
4. word_valid held high with 0x00000000 then 0xFFFFFFFF -> "0x00000000\r\n0xFFFFFFFF\r\n"; exactly one valid-low cycle between the two messages; exactly two words accepted.
5. Reset pulsed for one cycle after the 5th byte is accepted -> uart_in_valid=0 on that edge; word_ready=1 one cycle after reset falls; next word 0x0000CAFE prints "0x0000CAFE\r\n" complete.
6. DATA_WIDTH=8, PREFIX_EN=0, NEWLINE_EN=0, word 0xA5 -> exactly two bytes "A5" (41 35); then IDLE.
